// File: rtl/psram_init_seq.sv
// psram_init_seq: power-up / command sequencer for the serial PSRAM on the
// Tang Nano 1k. After start it waits DELAY_CYCLES, sends Reset-Enable (0x66)
// and Reset (0x99), optionally Enter-QPI (0x35), then accepts single-byte
// runtime commands and serialises them in SPI (1 bit/edge) or QPI (nibble).
// Ports:
//   sys_clk, rst_n (sync, active-low), start     - clock, reset, init request
//   cmd_valid/cmd_byte/cmd_ready                  - runtime command handshake
//   init_done, busy, qpi_mode, state_dbg          - status
//   mem_ce, mem_sclk, mem_sio_o, mem_sio_oe       - PSRAM pin drivers
module psram_init_seq #(
  parameter int unsigned DELAY_CYCLES = 4050,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned ENTER_QPI    = 0
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       busy,
  output logic       qpi_mode,
  output logic [2:0] state_dbg,
  output logic       mem_ce,
  output logic       mem_sclk,
  output logic [3:0] mem_sio_o,
  output logic [3:0] mem_sio_oe
);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_DELAY = 3'd1,
    S_SETUP = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5,
    S_IDLE  = 3'd6
  } state_t;

  localparam logic [15:0] DELAY_LAST = 16'(DELAY_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam bit          QPI_INIT   = (ENTER_QPI != 0);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic [7:0]  cur_byte;
  logic [1:0]  seq;        // init step: 0 = 0x66, 1 = 0x99, 2 = 0x35
  logic        xfer_qpi;   // mode frozen for the byte in flight
  logic        last_66;    // previous completed command was 0x66
  logic        start_seen;
  logic        shift_end;
  logic [3:0]  oe_mode;

  assign shift_end = xfer_qpi ? (idx == 4'd3) : (idx == 4'd15);
  assign oe_mode   = xfer_qpi ? 4'hF : 4'h1;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_WAIT) && (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nx   = state;
    mem_ce     = 1'b1;
    mem_sclk   = 1'b0;
    mem_sio_o  = '0;
    mem_sio_oe = '0;
    case (state)
      S_WAIT:  if (start || start_seen) state_nx = S_DELAY;
      S_DELAY: if (cnt == DELAY_LAST) state_nx = S_SETUP;
      S_SETUP: begin
        mem_ce     = 1'b0;
        mem_sio_o  = xfer_qpi ? cur_byte[7:4] : {3'b000, cur_byte[7]};
        mem_sio_oe = oe_mode;
        state_nx   = S_SHIFT;
      end
      S_SHIFT: begin
        mem_ce     = 1'b0;
        mem_sclk   = idx[0];
        // idx[0] is the sclk phase, so the data select only moves on the
        // falling half and is stable across each rising sclk.
        mem_sio_o  = xfer_qpi ? (idx[1] ? cur_byte[3:0] : cur_byte[7:4])
                              : {3'b000, cur_byte[3'd7 - idx[3:1]]};
        mem_sio_oe = oe_mode;
        if (shift_end) state_nx = S_HOLD;
      end
      S_HOLD: begin
        mem_ce     = 1'b0;
        mem_sio_o  = xfer_qpi ? cur_byte[3:0] : {3'b000, cur_byte[0]};
        mem_sio_oe = oe_mode;
        state_nx   = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          if (!init_done && (seq == 2'd0 || (seq == 2'd1 && QPI_INIT)))
            state_nx = S_SETUP;
          else
            state_nx = S_IDLE;
        end
      end
      S_IDLE:  if (cmd_valid) state_nx = S_SETUP;
      default: state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      cnt        <= '0;
      idx        <= '0;
      cur_byte   <= '0;
      seq        <= '0;
      xfer_qpi   <= 1'b0;
      last_66    <= 1'b0;
      start_seen <= 1'b0;
      qpi_mode   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) start_seen <= 1'b1;
      case (state)
        S_WAIT:  cnt <= '0;
        S_DELAY: begin
          cnt <= cnt + 16'd1;
          if (cnt == DELAY_LAST) begin
            cur_byte <= 8'h66;
            seq      <= 2'd0;
            xfer_qpi <= qpi_mode;
          end
        end
        S_SETUP: idx <= '0;
        S_SHIFT: idx <= idx + 4'd1;
        S_HOLD: begin
          // Mode side effects land on the HOLD->GAP edge (GAP entry).
          cnt <= '0;
          if (cur_byte == 8'h35) qpi_mode <= 1'b1;
          if (cur_byte == 8'hF5) qpi_mode <= 1'b0;
          if (cur_byte == 8'h99 && last_66) qpi_mode <= 1'b0;
          last_66 <= (cur_byte == 8'h66);
        end
        S_GAP: begin
          cnt <= cnt + 16'd1;
          if (cnt == GAP_LAST && !init_done) begin
            if (seq == 2'd0) begin
              cur_byte <= 8'h99;
              seq      <= 2'd1;
              xfer_qpi <= qpi_mode;
            end else if (seq == 2'd1 && QPI_INIT) begin
              cur_byte <= 8'h35;
              seq      <= 2'd2;
              xfer_qpi <= qpi_mode;
            end else begin
              init_done <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            cur_byte <= cmd_byte;
            xfer_qpi <= qpi_mode;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_init_seq.sv
// Bench for psram_init_seq: dut0 (ENTER_QPI=0) and dut1 (ENTER_QPI=1).
// Stimulus pushes the expected CE-low window {length, oe, beats, byte} into a
// per-DUT queue; a monitor decodes every CE-low window and compares.
module tb_psram_init_seq;
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [1:0]      rst_n, start, cmd_valid;
  logic [1:0][7:0] cmd_byte;
  logic [1:0]      cmd_ready, init_done, busy, qpi_mode, mem_ce, mem_sclk;
  logic [1:0][2:0] state_dbg;
  logic [1:0][3:0] mem_sio_o, mem_sio_oe;

  int tests = 0;
  int fails = 0;
  logic [23:0] expq0[$];
  logic [23:0] expq1[$];
  logic [1:0]  ign = 2'b00;

  psram_init_seq #(.DELAY_CYCLES(100), .GAP_CYCLES(4), .ENTER_QPI(0)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n[0]), .start(start[0]),
    .cmd_valid(cmd_valid[0]), .cmd_byte(cmd_byte[0]), .cmd_ready(cmd_ready[0]),
    .init_done(init_done[0]), .busy(busy[0]), .qpi_mode(qpi_mode[0]),
    .state_dbg(state_dbg[0]), .mem_ce(mem_ce[0]), .mem_sclk(mem_sclk[0]),
    .mem_sio_o(mem_sio_o[0]), .mem_sio_oe(mem_sio_oe[0]));

  psram_init_seq #(.DELAY_CYCLES(100), .GAP_CYCLES(4), .ENTER_QPI(1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n[1]), .start(start[1]),
    .cmd_valid(cmd_valid[1]), .cmd_byte(cmd_byte[1]), .cmd_ready(cmd_ready[1]),
    .init_done(init_done[1]), .busy(busy[1]), .qpi_mode(qpi_mode[1]),
    .state_dbg(state_dbg[1]), .mem_ce(mem_ce[1]), .mem_sclk(mem_sclk[1]),
    .mem_sio_o(mem_sio_o[1]), .mem_sio_oe(mem_sio_oe[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [7:0] b, input logic q);
    return q ? {8'd6, 4'hF, 4'd2, b} : {8'd18, 4'h1, 4'd8, b};
  endfunction

  task automatic push(input int d, input logic [7:0] b, input logic q);
    if (d == 0) expq0.push_back(mk(b, q));
    else        expq1.push_back(mk(b, q));
  endtask

  task automatic wait_st(input int d, input logic [2:0] s, input int max, input string name);
    int n = 0;
    while (state_dbg[d] !== s && n < max) begin
      @(negedge sys_clk);
      n++;
    end
    check({name, "_reached"}, 32'(state_dbg[d] === s), 32'd1);
  endtask

  // One-cycle cmd_valid pulse issued while the DUT sits in IDLE.
  task automatic issue(input int d, input logic [7:0] b, input string name);
    cmd_byte[d]  = b;
    cmd_valid[d] = 1'b1;
    @(negedge sys_clk);
    cmd_valid[d] = 1'b0;
    check({name, "_busy"}, 32'(busy[d]), 32'd1);
    check({name, "_ready_low"}, 32'(cmd_ready[d]), 32'd0);
    wait_st(d, 3'd6, 100, {name, "_idle"});
  endtask

  task automatic reset_dut(input int d);
    rst_n[d] = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n[d] = 1'b1;
  endtask

  // Monitor: decode each CE-low window, capture data on rising sclk.
  int          wlen[2];
  int          nb[2];
  logic [7:0]  sh[2];
  logic [3:0]  woe[2];
  logic        psc[2];
  logic        inw[2] = '{1'b0, 1'b0};
  logic [23:0] act_rec, exp_rec;
  logic        have;

  always @(negedge sys_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_ce[d] === 1'b0) begin
        if (!inw[d]) begin
          inw[d] = 1'b1; wlen[d] = 0; nb[d] = 0; sh[d] = '0;
          woe[d] = mem_sio_oe[d]; psc[d] = 1'b0;
        end
        wlen[d]++;
        if (mem_sclk[d] && !psc[d]) begin
          if (woe[d] == 4'hF) sh[d] = {sh[d][3:0], mem_sio_o[d]};
          else                sh[d] = {sh[d][6:0], mem_sio_o[d][0]};
          nb[d]++;
        end
        psc[d] = mem_sclk[d];
      end else if (inw[d]) begin
        inw[d] = 1'b0;
        if (!ign[d]) begin
          act_rec = {8'(wlen[d]), woe[d], 4'(nb[d]), sh[d]};
          have = 1'b0;
          exp_rec = '0;
          if (d == 0 && expq0.size() > 0) begin have = 1'b1; exp_rec = expq0.pop_front(); end
          if (d == 1 && expq1.size() > 0) begin have = 1'b1; exp_rec = expq1.pop_front(); end
          if (!have) check($sformatf("dut%0d_unexpected_xfer", d), {8'h0, act_rec}, 32'h0);
          else       check($sformatf("dut%0d_xfer{len,oe,beats,byte}", d), {8'h0, act_rec}, {8'h0, exp_rec});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, dce, gap, g, acc, nset, rdy_bad, activity;
    rst_n = '0; start = '0; cmd_valid = '0; cmd_byte = '0;
    repeat (3) @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_ce", d),    32'(mem_ce[d]), 32'd1);
      check($sformatf("rst%0d_sclk", d),  32'(mem_sclk[d]), 32'd0);
      check($sformatf("rst%0d_sio", d),   32'(mem_sio_o[d]), 32'd0);
      check($sformatf("rst%0d_oe", d),    32'(mem_sio_oe[d]), 32'd0);
      check($sformatf("rst%0d_done", d),  32'(init_done[d]), 32'd0);
      check($sformatf("rst%0d_busy", d),  32'(busy[d]), 32'd0);
      check($sformatf("rst%0d_qpi", d),   32'(qpi_mode[d]), 32'd0);
      check($sformatf("rst%0d_ready", d), 32'(cmd_ready[d]), 32'd0);
      check($sformatf("rst%0d_state", d), 32'(state_dbg[d]), 32'd0);
    end
    rst_n = '1;
    repeat (5) @(negedge sys_clk);
    check("wait_without_start", 32'(state_dbg[0]), 32'd0);

    // dut0 init: 100 DELAY cycles, 0x66, 4-cycle gap, 0x99.
    push(0, 8'h66, 1'b0);
    push(0, 8'h99, 1'b0);
    start[0] = 1'b1;
    @(negedge sys_clk);
    start[0] = 1'b0;
    dcnt = 0; dce = 0; g = 0;
    while (state_dbg[0] == 3'd1 && g < 1000) begin
      dcnt++;
      if (mem_ce[0]) dce++;
      @(negedge sys_clk);
      g++;
    end
    check("delay_len", 32'(dcnt), 32'd100);
    check("delay_ce_high", 32'(dce), 32'd100);
    check("after_delay_state", 32'(state_dbg[0]), 32'd2);
    g = 0;
    while (mem_ce[0] !== 1'b1 && g < 100) begin @(negedge sys_clk); g++; end
    gap = 0; g = 0;
    while (mem_ce[0] === 1'b1 && g < 100) begin gap++; @(negedge sys_clk); g++; end
    check("gap_len", 32'(gap), 32'd4);
    wait_st(0, 3'd6, 100, "init0_idle");
    check("init0_done", 32'(init_done[0]), 32'd1);
    check("init0_ready", 32'(cmd_ready[0]), 32'd1);
    check("init0_qpi", 32'(qpi_mode[0]), 32'd0);
    check("init0_busy", 32'(busy[0]), 32'd0);

    // Runtime 0xF5 in SPI mode.
    push(0, 8'hF5, 1'b0);
    issue(0, 8'hF5, "f5_spi");
    check("f5_spi_qpi_stays0", 32'(qpi_mode[0]), 32'd0);

    // cmd_valid held through init: exactly one accept once cmd_ready rises.
    reset_dut(0);
    push(0, 8'h66, 1'b0);
    push(0, 8'h99, 1'b0);
    push(0, 8'h3C, 1'b0);
    cmd_byte[0] = 8'h3C;
    cmd_valid[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge sys_clk);
    start[0] = 1'b0;
    acc = 0; nset = 0; rdy_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (acc > 0) cmd_valid[0] = 1'b0;
      if (state_dbg[0] == 3'd2) nset++;
      if (cmd_ready[0] && cmd_valid[0]) acc++;
      if (cmd_ready[0] && !init_done[0]) rdy_bad++;
      if (cmd_ready[0] && state_dbg[0] != 3'd6) rdy_bad++;
      if (cmd_ready[0] && busy[0]) rdy_bad++;
    end
    check("held_valid_accepts", 32'(acc), 32'd1);
    check("held_valid_setups", 32'(nset), 32'd3);
    check("held_valid_ready_bad", 32'(rdy_bad), 32'd0);
    check("held_valid_end_idle", 32'(state_dbg[0]), 32'd6);

    // Reset at SHIFT idx=7 of the init 0x66.
    ign[0] = 1'b1;
    reset_dut(0);
    start[0] = 1'b1;
    @(negedge sys_clk);
    start[0] = 1'b0;
    wait_st(0, 3'd2, 200, "abort_setup");
    repeat (8) @(negedge sys_clk);
    check("abort_pre_state", 32'(state_dbg[0]), 32'd3);
    check("abort_pre_sclk", 32'(mem_sclk[0]), 32'd1);
    check("abort_pre_bit4_of_66", 32'(mem_sio_o[0]), 32'd0);
    check("abort_pre_oe", 32'(mem_sio_oe[0]), 32'd1);
    rst_n[0] = 1'b0;
    @(negedge sys_clk);
    check("abort_ce", 32'(mem_ce[0]), 32'd1);
    check("abort_oe", 32'(mem_sio_oe[0]), 32'd0);
    check("abort_state", 32'(state_dbg[0]), 32'd0);
    rst_n[0] = 1'b1;
    activity = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (!mem_ce[0] || mem_sclk[0] || state_dbg[0] != 3'd0 || mem_sio_oe[0] != 4'h0) activity++;
    end
    check("abort_quiet_200", 32'(activity), 32'd0);
    ign[0] = 1'b0;

    // dut1: init with Enter-QPI, then QPI runtime traffic.
    push(1, 8'h66, 1'b0);
    push(1, 8'h99, 1'b0);
    push(1, 8'h35, 1'b0);
    start[1] = 1'b1;
    @(negedge sys_clk);
    start[1] = 1'b0;
    wait_st(1, 3'd6, 500, "init1_idle");
    check("init1_done", 32'(init_done[1]), 32'd1);
    check("init1_qpi", 32'(qpi_mode[1]), 32'd1);
    push(1, 8'hA5, 1'b1);
    issue(1, 8'hA5, "a5_qpi");
    push(1, 8'h66, 1'b1);
    issue(1, 8'h66, "66_qpi");
    check("66_qpi_keeps_qpi", 32'(qpi_mode[1]), 32'd1);
    push(1, 8'h99, 1'b1);
    cmd_byte[1] = 8'h99;
    cmd_valid[1] = 1'b1;
    @(negedge sys_clk);
    cmd_valid[1] = 1'b0;
    wait_st(1, 3'd4, 50, "99_qpi_hold");
    check("99_qpi_hold_qpi", 32'(qpi_mode[1]), 32'd1);
    @(negedge sys_clk);
    check("99_qpi_gap_state", 32'(state_dbg[1]), 32'd5);
    check("99_qpi_gap_cleared", 32'(qpi_mode[1]), 32'd0);
    wait_st(1, 3'd6, 100, "99_qpi_idle");
    push(1, 8'h35, 1'b0);
    issue(1, 8'h35, "35_spi");
    check("35_spi_sets_qpi", 32'(qpi_mode[1]), 32'd1);
    push(1, 8'hF5, 1'b1);
    issue(1, 8'hF5, "f5_qpi");
    check("f5_qpi_clears", 32'(qpi_mode[1]), 32'd0);
    push(1, 8'h35, 1'b0);
    issue(1, 8'h35, "35_spi_again");
    push(1, 8'h99, 1'b1);
    issue(1, 8'h99, "99_after_35");
    check("99_without_66_keeps_qpi", 32'(qpi_mode[1]), 32'd1);

    repeat (3) @(negedge sys_clk);
    check("dut0_queue_drained", 32'(expq0.size()), 32'd0);
    check("dut1_queue_drained", 32'(expq1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
